// File: rtl/ssp_bus_initiator.sv
// Host-side bus initiator: turns VDP/PSG commands into ordered 6502-style bus
// cycles on a generated phi0 timebase, aimed at the SuperSprite device registers.
module ssp_bus_initiator #(
    parameter int          SLOT           = 7,
    parameter logic [15:0] DEVICE_ADDRESS = 16'hC080 + 16'(SLOT << 4),
    parameter int          CYCLE_CLKS     = 54
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [13:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        phi0_o,
    output logic        phi1_posedge_o,
    output logic        phi1_negedge_o,
    output logic [15:0] addr_o,
    output logic [7:0]  data_o,
    input  logic [7:0]  data_i,
    output logic        rw_n_o,
    output logic        m2sel_n_o
);
    localparam int               CNT_W    = $clog2(CYCLE_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLE_CLKS / 2);

    localparam logic [2:0] OP_VRAM_ADDR = 3'd0;
    localparam logic [2:0] OP_VRAM_DATA = 3'd1;
    localparam logic [2:0] OP_VDP_REG   = 3'd2;
    localparam logic [2:0] OP_PSG_REG   = 3'd3;
    localparam logic [2:0] OP_STATUS_RD = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_CYC1, S_CYC2} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             pend_q, pend_d;
    logic [2:0]       op_q, op_d;
    logic [13:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [15:0]      bus_addr_q, bus_addr_d;
    logic [7:0]       bus_data_q, bus_data_d;
    logic             bus_rw_n_q, bus_rw_n_d;
    logic             bus_m2sel_n_q, bus_m2sel_n_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    logic        cmd_hs;
    logic        cycle_start;
    logic        cycle_end;
    logic [2:0]  eff_op;
    logic [13:0] eff_addr;
    logic [7:0]  eff_data;

    function automatic logic is_two_cycle(input logic [2:0] op);
        return (op == OP_VRAM_ADDR) || (op == OP_VDP_REG) || (op == OP_PSG_REG);
    endfunction

    assign cmd_ready_o    = run_q && (state_q == S_IDLE) && !pend_q;
    assign cmd_hs         = cmd_valid_i && cmd_ready_o;
    // cycle_start is the edge where cnt becomes 1: the only edge bus fields may change.
    assign cycle_start    = (cnt_q == '0);
    assign cycle_end      = (cnt_q == CNT_LAST);

    assign phi0_o         = (cnt_q >= CNT_HALF);
    assign phi1_posedge_o = run_q && (cnt_q == '0);
    assign phi1_negedge_o = run_q && (cnt_q == CNT_HALF);
    assign addr_o         = bus_addr_q;
    assign data_o         = bus_data_q;
    assign rw_n_o         = bus_rw_n_q;
    assign m2sel_n_o      = bus_m2sel_n_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        cnt_d         = cycle_end ? '0 : cnt_q + 1'b1;
        state_d       = state_q;
        pend_d        = pend_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        bus_addr_d    = bus_addr_q;
        bus_data_d    = bus_data_q;
        bus_rw_n_d    = bus_rw_n_q;
        bus_m2sel_n_d = bus_m2sel_n_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        eff_op        = op_q;
        eff_addr      = addr_q;
        eff_data      = data_q;

        // A command accepted on the cycle_start clock must launch on that same edge.
        if (cmd_hs) begin
            op_d     = cmd_op_i;
            addr_d   = cmd_addr_i;
            data_d   = cmd_data_i;
            pend_d   = 1'b1;
            eff_op   = cmd_op_i;
            eff_addr = cmd_addr_i;
            eff_data = cmd_data_i;
        end

        if (cycle_end) begin
            if (state_q == S_CYC1 && op_q == OP_STATUS_RD) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_i;
            end
            if (state_q == S_CYC2 || (state_q == S_CYC1 && !is_two_cycle(op_q))) begin
                state_d = S_IDLE;
            end
        end

        if (cycle_start) begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q || cmd_hs) begin
                        pend_d = 1'b0;
                        if (eff_op <= OP_STATUS_RD) state_d = S_CYC1;
                    end
                end
                S_CYC1:  state_d = S_CYC2;
                default: state_d = S_IDLE;
            endcase

            bus_addr_d    = 16'h0000;
            bus_data_d    = 8'h00;
            bus_rw_n_d    = 1'b1;
            bus_m2sel_n_d = 1'b1;
            if (state_d == S_CYC1) begin
                bus_m2sel_n_d = 1'b0;
                bus_rw_n_d    = 1'b0;
                case (eff_op)
                    OP_VRAM_ADDR: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'h1;
                        bus_data_d = eff_addr[7:0];
                    end
                    OP_VRAM_DATA: begin
                        bus_addr_d = DEVICE_ADDRESS;
                        bus_data_d = eff_data;
                    end
                    OP_VDP_REG: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'h1;
                        bus_data_d = eff_data;
                    end
                    OP_PSG_REG: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'hE;
                        bus_data_d = {4'h0, eff_addr[3:0]};
                    end
                    default: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'h1;
                        bus_rw_n_d = 1'b1;
                    end
                endcase
            end else if (state_d == S_CYC2) begin
                bus_m2sel_n_d = 1'b0;
                bus_rw_n_d    = 1'b0;
                case (eff_op)
                    OP_VRAM_ADDR: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'h1;
                        bus_data_d = {2'b01, eff_addr[13:8]};
                    end
                    OP_VDP_REG: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'h1;
                        bus_data_d = {1'b1, eff_addr[6:0]};
                    end
                    default: begin
                        bus_addr_d = DEVICE_ADDRESS + 16'hC;
                        bus_data_d = eff_data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            cnt_q         <= '0;
            state_q       <= S_IDLE;
            run_q         <= 1'b0;
            pend_q        <= 1'b0;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            bus_addr_q    <= 16'h0000;
            bus_data_q    <= 8'h00;
            bus_rw_n_q    <= 1'b1;
            bus_m2sel_n_q <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            run_q         <= 1'b1;
            pend_q        <= pend_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_q    <= bus_data_d;
            bus_rw_n_q    <= bus_rw_n_d;
            bus_m2sel_n_q <= bus_m2sel_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_ssp_bus_initiator.sv
// Directed bench for ssp_bus_initiator: logs every bus cycle at its phi1 end
// and compares against hand-computed C0Fx accesses for slot 7.
module tb_ssp_bus_initiator;
    localparam int N = 54;

    localparam logic [2:0] OP_VRAM_ADDR = 3'd0;
    localparam logic [2:0] OP_VRAM_DATA = 3'd1;
    localparam logic [2:0] OP_VDP_REG   = 3'd2;
    localparam logic [2:0] OP_PSG_REG   = 3'd3;
    localparam logic [2:0] OP_STATUS_RD = 3'd4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw_n;
        logic        m2sel_n;
    } bus_t;

    logic        clk_logic = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i = '0;
    logic [13:0] cmd_addr_i = '0;
    logic [7:0]  cmd_data_i = '0;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        phi0_o;
    logic        phi1_posedge_o;
    logic        phi1_negedge_o;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic [7:0]  data_i = 8'h00;
    logic        rw_n_o;
    logic        m2sel_n_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   stab_err = 0;
    bus_t bus_log[$];
    bus_t mid_snap;
    logic mid_ok = 1'b0;

    ssp_bus_initiator dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_data_i     (cmd_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .phi0_o         (phi0_o),
        .phi1_posedge_o (phi1_posedge_o),
        .phi1_negedge_o (phi1_negedge_o),
        .addr_o         (addr_o),
        .data_o         (data_o),
        .data_i         (data_i),
        .rw_n_o         (rw_n_o),
        .m2sel_n_o      (m2sel_n_o)
    );

    always #5 clk_logic = ~clk_logic;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // One log entry per bus cycle, taken on its closing phi1 strobe; fields must
    // also be unchanged since the phi0 rise of the same cycle.
    always @(negedge clk_logic) begin
        bus_t cur;
        cur = '{addr: addr_o, data: data_o, rw_n: rw_n_o, m2sel_n: m2sel_n_o};
        if (!system_reset_n) begin
            mid_ok = 1'b0;
        end else begin
            if (phi1_negedge_o) begin
                mid_snap = cur;
                mid_ok   = 1'b1;
            end
            if (phi1_posedge_o) begin
                if (mid_ok && cur != mid_snap) stab_err++;
                mid_ok = 1'b0;
                bus_log.push_back(cur);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bus_t log_at(input int idx);
        if (idx >= 0 && idx < bus_log.size()) return bus_log[idx];
        return '1;
    endfunction

    function automatic int first_active();
        foreach (bus_log[i]) if (!bus_log[i].m2sel_n) return i;
        return -1;
    endfunction

    function automatic int count_active();
        int n = 0;
        foreach (bus_log[i]) if (!bus_log[i].m2sel_n || bus_log[i].addr != 16'h0) n++;
        return n;
    endfunction

    function automatic logic [31:0] wr(input logic [15:0] a, input logic [7:0] d);
        bus_t b;
        b = '{addr: a, data: d, rw_n: 1'b0, m2sel_n: 1'b0};
        return {6'b0, b};
    endfunction

    task automatic wait_bus(input int cycles);
        repeat (cycles * N) @(negedge clk_logic);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [13:0] addr, input logic [7:0] data);
        int n = 0;
        @(negedge clk_logic);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        while (!cmd_ready_o && n < 8 * N) begin
            @(negedge clk_logic);
            n++;
        end
        check("send_ready", {31'b0, cmd_ready_o}, 32'd1);
        @(posedge clk_logic);
        #1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 3'($urandom);
        cmd_addr_i  = 14'($urandom);
        cmd_data_i  = 8'($urandom);
    endtask

    initial begin
        int   idx;
        int   n;
        int   pulses;
        logic prev;
        logic [7:0] rsp_seen;
        logic strobe_seen;

        // Reset / idle
        repeat (5) @(posedge clk_logic);
        @(negedge clk_logic);
        check("rst_ready",   {31'b0, cmd_ready_o}, 32'd0);
        check("rst_phi0",    {31'b0, phi0_o}, 32'd0);
        check("rst_strobes", {30'b0, phi1_posedge_o, phi1_negedge_o}, 32'd0);
        check("rst_bus",     {6'b0, addr_o, data_o, rw_n_o, m2sel_n_o}, {6'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
        check("rst_rsp",     {23'b0, rsp_valid_o, rsp_data_o}, 32'd0);
        system_reset_n = 1'b1;
        @(negedge clk_logic);
        check("ready_after_release", {31'b0, cmd_ready_o}, 32'd1);

        bus_log.delete();
        prev = phi0_o;
        n = 0;
        while (phi0_o == prev && n < 2 * N) begin @(negedge clk_logic); n++; end
        for (int h = 0; h < 2; h++) begin
            prev = phi0_o;
            n = 0;
            while (phi0_o == prev && n < 2 * N) begin @(negedge clk_logic); n++; end
            check("phi0_half_period", n, 27);
        end
        wait_bus(1);
        check("idle_cycles_logged", {31'b0, bus_log.size() >= 2}, 32'd1);
        check("idle_no_access", count_active(), 0);

        // VRAM address set
        bus_log.delete();
        send_cmd(OP_VRAM_ADDR, 14'h1234, 8'h00);
        check("ready_drops", {31'b0, cmd_ready_o}, 32'd0);
        wait_bus(4);
        idx = first_active();
        check("vaddr_c1",   {6'b0, log_at(idx)},     wr(16'hC0F1, 8'h34));
        check("vaddr_c2",   {6'b0, log_at(idx + 1)}, wr(16'hC0F1, 8'h52));
        check("vaddr_idle", {31'b0, log_at(idx + 2).m2sel_n}, 32'd1);

        // VDP register then VRAM data, back to back
        bus_log.delete();
        send_cmd(OP_VDP_REG, 14'd7, 8'hF5);
        send_cmd(OP_VRAM_DATA, 14'h0000, 8'hAA);
        wait_bus(3);
        idx = first_active();
        check("vreg_c1",  {6'b0, log_at(idx)},     wr(16'hC0F1, 8'hF5));
        check("vreg_c2",  {6'b0, log_at(idx + 1)}, wr(16'hC0F1, 8'h87));
        check("vdata_c1", {6'b0, log_at(idx + 2)}, wr(16'hC0F0, 8'hAA));

        // PSG register write
        bus_log.delete();
        send_cmd(OP_PSG_REG, 14'd8, 8'h0F);
        wait_bus(4);
        idx = first_active();
        check("psg_c1", {6'b0, log_at(idx)},     wr(16'hC0FE, 8'h08));
        check("psg_c2", {6'b0, log_at(idx + 1)}, wr(16'hC0FC, 8'h0F));

        // Reserved op issues nothing
        bus_log.delete();
        send_cmd(3'd6, 14'h1FFF, 8'h55);
        wait_bus(2);
        check("reserved_no_access", count_active(), 0);
        check("reserved_ready", {31'b0, cmd_ready_o}, 32'd1);

        // Status read
        bus_log.delete();
        data_i = 8'hA0;
        pulses = 0;
        rsp_seen = 8'h00;
        strobe_seen = 1'b0;
        send_cmd(OP_STATUS_RD, 14'h0000, 8'h00);
        for (int c = 0; c < 4 * N; c++) begin
            @(negedge clk_logic);
            if (rsp_valid_o) begin
                pulses++;
                rsp_seen    = rsp_data_o;
                strobe_seen = phi1_posedge_o;
            end
        end
        idx = first_active();
        check("status_cycle", {6'b0, log_at(idx)}, {6'b0, 16'hC0F1, 8'h00, 1'b1, 1'b0});
        check("status_pulses", pulses, 1);
        check("status_data", {24'b0, rsp_seen}, 32'h0000_00A0);
        check("status_at_cnt0", {31'b0, strobe_seen}, 32'd1);
        data_i = 8'h55;
        wait_bus(1);
        check("status_held", {24'b0, rsp_data_o}, 32'h0000_00A0);

        // Reset in the middle of a VRAM address op
        send_cmd(OP_VRAM_ADDR, 14'h1234, 8'h00);
        n = 0;
        while (m2sel_n_o && n < 2 * N) begin @(negedge clk_logic); n++; end
        check("midop_started", {31'b0, m2sel_n_o}, 32'd0);
        repeat (5) @(negedge clk_logic);
        system_reset_n = 1'b0;
        @(negedge clk_logic);
        check("midop_rst_bus", {6'b0, addr_o, data_o, rw_n_o, m2sel_n_o}, {6'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
        check("midop_rst_ctl", {29'b0, cmd_ready_o, phi0_o, phi1_posedge_o}, 32'd0);
        repeat (3) @(negedge clk_logic);
        bus_log.delete();
        system_reset_n = 1'b1;
        wait_bus(4);
        check("midop_no_resume", count_active(), 0);
        check("midop_ready", {31'b0, cmd_ready_o}, 32'd1);

        check("bus_stable", stab_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ssp_bus_initiator.md
# ssp_bus_initiator

Apple II bus-cycle initiator that drives the SuperSprite card's device registers from a simple command stream. It converts VDP VRAM-address, VRAM-data, VDP-register, PSG-register and VDP-status-read commands into correctly ordered 6502-style bus cycles on a generated phi0 timebase. Those cycles go to addresses DEVICE_ADDRESS+0/+1/+C/+E. It sits on the host side of the bus model, for bring-up and self-test of the card logic without a real Apple II.

## Interface
- SLOT, 7, card slot number.
- DEVICE_ADDRESS, 16'hC080 + (SLOT << 4), base of the card's device-select space.
- CYCLE_CLKS, 54, clk_logic clocks per bus cycle; even, ≥ 8.
- clk_logic  in  1  single clock for all logic.
- system_reset_n  in  1  reset; synchronous and active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid && ready.
- cmd_op_i  in  3  0 VRAM_ADDR, 1 VRAM_DATA, 2 VDP_REG, 3 PSG_REG, 4 STATUS_RD; 5–7 reserved.
- cmd_addr_i  in  14  VRAM address, VDP register number [6:0], or PSG register [3:0].
- cmd_data_i  in  8  write data.
- rsp_valid_o  out  1  one-clock pulse, status byte valid.
- rsp_data_o  out  8  captured read data.
- phi0_o  out  1  bus phase clock.
- phi1_posedge_o  out  1  one-clock strobe when phi0 falls.
- phi1_negedge_o  out  1  one-clock strobe when phi0 rises.
- addr_o  out  16  bus address.
- data_o  out  8  bus write data.
- data_i  in  8  bus read data from the card.
- rw_n_o  out  1  1 read, 0 write.
- m2sel_n_o  out  1  low during an issued access.

## Operation
- Phase counter cnt runs 0..N-1, with N=CYCLE_CLKS and H=N/2. phi0_o=0 for cnt<H and 1 for cnt≥H. phi1_posedge_o=1 at cnt==0; phi1_negedge_o=1 at cnt==H.
- FSM states: IDLE, CYC1, CYC2.
- cmd_ready_o = (state==IDLE) and reset deasserted. On handshake, latch op/addr/data and go to CYC1 at the next cnt==1.
- Per-op bus cycles (writes unless noted):
  - VRAM_ADDR: two cycles. CYC1 writes addr[7:0] to +1. CYC2 writes {2'b01, addr[13:8]} to +1.
  - VRAM_DATA: one cycle, writes data to +0.
  - VDP_REG: two cycles. CYC1 writes data to +1. CYC2 writes {1'b1, addr[6:0]} to +1.
  - PSG_REG: two cycles. CYC1 writes {4'h0, addr[3:0]} to +E. CYC2 writes data to +C.
  - STATUS_RD: one read cycle at +1.
- Reserved op: accepted, no bus cycle issued, back to IDLE at the next cnt==1.
- Idle cycles drive addr_o=16'h0000, data_o=0, rw_n_o=1, m2sel_n_o=1.
- For reads, data_o=0 and rw_n_o=1. data_i is sampled at cnt==N-1, and rsp_valid_o pulses at the following cnt==0 with rsp_data_o held until the next read.
- After the final cycle of an op, the FSM returns to IDLE at cnt==0. A new command accepted that same clock starts at cnt==1, so back-to-back ops have no idle bus cycle.

## Timing
- Reset (system_reset_n=0 sampled at a clock edge):
  - cnt=0 and state=IDLE; latched command discarded.
  - phi0_o=0; both strobes=0; rsp_valid_o=0; rsp_data_o=0.
  - addr_o=0, data_o=0, rw_n_o=1, m2sel_n_o=1, cmd_ready_o=0.
- After reset release, cnt advances each clock from 0. Reset asserted mid-cycle aborts immediately; no partial second cycle is ever issued.
- Bus fields (addr_o, data_o, rw_n_o, m2sel_n_o) change only on the clock where cnt becomes 1. They are stable through phi0 high and the next phi1_posedge_o clock, where the card samples its soft switches.
- Command latency: handshake at cnt==k. The op's first bus cycle drives its fields from the next cnt==1; if k==0 that is the immediately following clock.
- cmd_ready_o drops the clock after handshake and stays low until the FSM returns to IDLE.
- Inputs are ignored while not ready; cmd_* fields need not be held after handshake.
- cnt wraps N-1 → 0 unconditionally; there is no stall state.

## Test plan
- Reset/idle: hold reset 5 clocks, release. Required: cmd_ready_o=1 next clock; phi0_o toggles every 27 clocks (N=54); addr_o=0000 with m2sel_n_o=1 throughout idle.
- VRAM address set: VRAM_ADDR with addr=14'h1234. Required: cycle 1 writes C0F1←34, cycle 2 writes C0F1←52, rw_n_o=0 with m2sel_n_o=0 in both, then idle.
- Register + data back-to-back: VDP_REG (reg 7, data F5) then VRAM_DATA AA, second presented while first is in progress. Required: contiguous cycles C0F1←F5, C0F1←87, C0F0←AA with no idle gap.
- PSG write: PSG_REG with reg 8, data 0F. Required: C0FE←08 then C0FC←0F.
- Status read: STATUS_RD with data_i=8'hA0 during phi0. Required: one read cycle at C0F1 (rw_n_o=1); rsp_valid_o pulses once at the next cnt==0 with rsp_data_o=A0.
- Reset mid-op: assert reset during CYC1 of VRAM_ADDR. Required: outputs return to reset values next clock; no C0F1 write with bit 6 set appears after release.
